// File: rtl/r_count_gen_pkg.sv
// ----------------------------------------------------------------------------
// r_cnt_pkg
// Shared definitions for the adder-tree drain counter (r_count_gen):
//   - r_state_e        : counter state encoding (R_IDLE, R_COUNT)
//   - R_STAGES_CH34    : adder-tree depth for 3/4-channel layers
//   - R_STAGES_CH816   : adder-tree depth for 8/16-channel layers
//   - r_len_first()    : drain length of the first run after a tile start
//   - r_len_next()     : drain length of every later run in the same tile
// All functions are constant functions evaluated at elaboration time.
// ----------------------------------------------------------------------------
package r_cnt_pkg;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_COUNT = 1'b1
    } r_state_e;

    localparam int R_STAGES_CH34  = 4;
    localparam int R_STAGES_CH816 = 5;

    // First run has to wait for the full adder tree plus the output register.
    function automatic int r_len_first(input int add_stages);
        return 1 + add_stages;
    endfunction

    // Later runs overlap the next loop nest: when the loop body (a) is at
    // least as long as the tree (b) the full tree latency is still needed,
    // otherwise only the part not hidden behind the loop body remains.
    function automatic int r_len_next(input int a, input int b);
        if (a >= b) begin
            return b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/r_count_gen.sv
// ----------------------------------------------------------------------------
// r_count_gen
// Adder-tree drain counter. Each innermost-loop wrap (k_zero) starts a count
// of the adder-tree latency; r_done pulses for one cycle when the accumulated
// result is valid. A trigger arriving mid-count is buffered one deep.
//
// Optional feature macro: R_CNT_STATUS_EN (adds r_cnt and overrun ports).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   tile/layer start: aborts any count, re-arms first-run length
//   k_zero   in   innermost-loop wrap, triggers one drain count
//   r_done   out  one-cycle pulse, drain complete (decoded from registers)
//   busy     out  high while counting
//   r_cnt    out  current count               (R_CNT_STATUS_EN only)
//   overrun  out  sticky, a trigger was dropped (R_CNT_STATUS_EN only)
// ----------------------------------------------------------------------------
module r_count_gen
    import r_cnt_pkg::*;
#(
    parameter int  LMAX       = 0,
    parameter int  JMAX       = 1,
    parameter int  KMAX       = 1,
    parameter int  ADD_STAGES = R_STAGES_CH34,
    localparam int A          = (1 + LMAX) * (1 + JMAX) * (1 + KMAX),
    localparam int B          = 1 + ADD_STAGES,
    localparam int LEN_FIRST  = r_len_first(ADD_STAGES),
    localparam int LEN_NEXT   = r_len_next(A, B),
    localparam int CNT_W      = $clog2(LEN_FIRST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             k_zero,
    output logic             r_done,
    output logic             busy
`ifdef R_CNT_STATUS_EN
    ,
    output logic [CNT_W-1:0] r_cnt,
    output logic             overrun
`endif
);

    localparam logic [CNT_W-1:0] LEN_FIRST_C = CNT_W'(LEN_FIRST);
    localparam logic [CNT_W-1:0] LEN_NEXT_C  = CNT_W'(LEN_NEXT);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

    r_state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic             first_q, first_d;
    logic             pend_q,  pend_d;
    logic             load_s;
    logic             done_s;
`ifdef R_CNT_STATUS_EN
    logic             ovr_q,   ovr_d;
`endif

    // Next-state logic: start aborts, otherwise idle/count/reload decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        first_d = first_q;
        pend_d  = pend_q;
        load_s  = 1'b0;
`ifdef R_CNT_STATUS_EN
        ovr_d   = ovr_q;
`endif
        done_s  = (state_q == R_COUNT) && (cnt_q == len_q);

        if (start) begin
            // A k_zero in the same cycle is deliberately ignored.
            state_d = R_IDLE;
            cnt_d   = CNT_ZERO_C;
            first_d = 1'b1;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (k_zero) begin
                        load_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                end
                R_COUNT: begin
                    if (cnt_q < len_q) begin
                        cnt_d = cnt_q + CNT_ONE_C;
                        if (k_zero && !pend_q) begin
                            pend_d = 1'b1;
                        end else if (k_zero) begin
`ifdef R_CNT_STATUS_EN
                            ovr_d = 1'b1;
`else
                            pend_d = pend_q;
`endif
                        end else begin
                            pend_d = pend_q;
                        end
                    end else begin
                        // Final cycle: a live or buffered trigger chains a new
                        // run with no idle gap; both together still load once.
                        if (k_zero || pend_q) begin
                            load_s = 1'b1;
                            pend_d = 1'b0;
                        end else begin
                            state_d = R_IDLE;
                            cnt_d   = CNT_ZERO_C;
                        end
                    end
                end
                default: begin
                    state_d = R_IDLE;
                    cnt_d   = CNT_ZERO_C;
                end
            endcase

            if (load_s) begin
                len_d   = first_q ? LEN_FIRST_C : LEN_NEXT_C;
                cnt_d   = CNT_ONE_C;
                first_d = 1'b0;
                state_d = R_COUNT;
            end else begin
                len_d = len_q;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= R_IDLE;
            cnt_q   <= CNT_ZERO_C;
            len_q   <= LEN_FIRST_C;
            first_q <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            first_q <= first_d;
            pend_q  <= pend_d;
        end
    end

`ifdef R_CNT_STATUS_EN
    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign r_cnt   = cnt_q;
    assign overrun = ovr_q;
`endif

    // Outputs decode registered state only; no input reaches them.
    assign r_done = done_s;
    assign busy   = (state_q == R_COUNT);

endmodule

// File: tb/tb_r_count_gen.sv
module tb_r_count_gen;

    logic       clk = 1'b0;
    logic       rst0, start0, kz0, done0, busy0;
    logic       rst6, start6, kz6, done6, busy6;
`ifdef R_CNT_STATUS_EN
    logic [2:0] cnt0, cnt6;
    logic       ovr0, ovr6;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int q0[$];
    int q6[$];
    int c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Defaults: A=4, B=5, LEN_FIRST=5, LEN_NEXT=1
    r_count_gen dut0 (
        .clk    (clk),
        .rst    (rst0),
        .start  (start0),
        .k_zero (kz0),
        .r_done (done0),
        .busy   (busy0)
`ifdef R_CNT_STATUS_EN
        ,
        .r_cnt  (cnt0),
        .overrun(ovr0)
`endif
    );

    // A=8, B=6: LEN_FIRST=LEN_NEXT=6
    r_count_gen #(.LMAX(1), .JMAX(1), .KMAX(1), .ADD_STAGES(5)) dut6 (
        .clk    (clk),
        .rst    (rst6),
        .start  (start6),
        .k_zero (kz6),
        .r_done (done6),
        .busy   (busy6)
`ifdef R_CNT_STATUS_EN
        ,
        .r_cnt  (cnt6),
        .overrun(ovr6)
`endif
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for dut0: every r_done must match the next expected cycle.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) chk("done0_spurious", done0, 0);
            else                chk("done0_cycle", cyc, q0.pop_front());
        end
    end

    // Scoreboard for dut6.
    always @(negedge clk) begin
        if (done6 === 1'b1) begin
            if (q6.size() == 0) chk("done6_spurious", done6, 0);
            else                chk("done6_cycle", cyc, q6.pop_front());
        end
    end

    initial begin
        rst0 = 1'b0; start0 = 1'b0; kz0 = 1'b0;
        rst6 = 1'b0; start6 = 1'b0; kz6 = 1'b0;
        step(2);
        chk("rst_done", done0, 0);
        chk("rst_busy", busy0, 0);
`ifdef R_CNT_STATUS_EN
        chk("rst_cnt", cnt0, 0);
        chk("rst_ovr", ovr0, 0);
`endif
        @(negedge clk);
        rst0 = 1'b1; rst6 = 1'b1;
        step(1);

        // Scenario 1: first run length 5, second run length 1.
        c = cyc; q0.push_back(c + 5);
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        chk("s1_busy_run", busy0, 1);
        step(6);
        chk("s1_busy_idle", busy0, 0);
        c = cyc; q0.push_back(c + 1);
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        step(3);
        chk("s1_busy_idle2", busy0, 0);

        // Scenario 3: pending trigger then overrun within the first run.
        start0 = 1'b1; step(1); start0 = 1'b0;
        chk("s3_start_busy", busy0, 0);
        c = cyc; q0.push_back(c + 5); q0.push_back(c + 6);
        kz0 = 1'b1; step(3); kz0 = 1'b0;
`ifdef R_CNT_STATUS_EN
        chk("s3_overrun", ovr0, 1);
`endif
        step(3);
        chk("s3_busy_b2b", busy0, 1);
        step(3);
        chk("s3_busy_end", busy0, 0);

        // Scenario 4: start with simultaneous k_zero mid-count aborts the run.
        start0 = 1'b1; step(1); start0 = 1'b0;
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        step(1);
        start0 = 1'b1; kz0 = 1'b1; step(1); start0 = 1'b0; kz0 = 1'b0;
        chk("s4_busy", busy0, 0);
        chk("s4_done", done0, 0);
`ifdef R_CNT_STATUS_EN
        chk("s4_cnt", cnt0, 0);
        chk("s4_ovr_kept", ovr0, 1);
`endif
        step(6);
        c = cyc; q0.push_back(c + 5);
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        step(6);

        // Scenario 5: asynchronous reset mid-count, then LEN_FIRST again.
        c = cyc; q0.push_back(c + 1);
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        step(2);
        start0 = 1'b1; step(1); start0 = 1'b0;
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        step(2);
`ifdef R_CNT_STATUS_EN
        chk("s5_cnt_pre", cnt0, 3);
`endif
        #2 rst0 = 1'b0;
        #1;
        chk("s5_rst_busy", busy0, 0);
        chk("s5_rst_done", done0, 0);
`ifdef R_CNT_STATUS_EN
        chk("s5_rst_cnt", cnt0, 0);
        chk("s5_rst_ovr", ovr0, 0);
`endif
        @(negedge clk);
        rst0 = 1'b1;
        step(1);
        c = cyc; q0.push_back(c + 5);
        kz0 = 1'b1; step(1); kz0 = 1'b0;
        step(6);

        // Scenario 2: A>=B, every run length 6 including back-to-back.
        c = cyc; q6.push_back(c + 6);
        kz6 = 1'b1; step(1); kz6 = 1'b0;
        step(7);
        c = cyc; q6.push_back(c + 6);
        kz6 = 1'b1; step(1); kz6 = 1'b0;
        step(7);
        c = cyc; q6.push_back(c + 6); q6.push_back(c + 12);
        kz6 = 1'b1; step(2); kz6 = 1'b0;
        step(8);
        chk("s2_busy_b2b", busy6, 1);
        step(5);
        chk("s2_busy_end", busy6, 0);

        step(2);
        chk("q0_drained", q0.size(), 0);
        chk("q6_drained", q6.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
